// File: rtl/std_slot_allocator.sv
// Tag slot allocator: grants the lowest free slot over valid/ready, reclaims
// slots on binary frees, flags double frees, and reports occupancy.
module std_slot_allocator #(
    parameter int ID_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_alloc_valid,
    output logic [ID_WIDTH-1:0]     o_alloc_id,
    input  logic                    i_alloc_ready,
    input  logic                    i_free_valid,
    input  logic [ID_WIDTH-1:0]     i_free_id,
    output logic                    o_free_error,
    output logic [(1<<ID_WIDTH)-1:0] o_busy,
    output logic [ID_WIDTH:0]       o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int SLOTS = 1 << ID_WIDTH;

    logic [SLOTS-1:0]    busy;
    logic [SLOTS-1:0]    busy_next;
    logic [SLOTS-1:0]    set_mask;
    logic [SLOTS-1:0]    clr_mask;
    logic                alloc_fire;
    logic                free_hit;
    logic                free_err;
    logic                next_valid;
    logic [ID_WIDTH-1:0] next_id;
    logic [ID_WIDTH:0]   next_count;

    assign alloc_fire = o_alloc_valid && i_alloc_ready;
    // A free only counts as legal against the registered state, so freeing the
    // slot being granted this same cycle is a double free.
    assign free_hit   = i_free_valid && busy[i_free_id];
    assign free_err   = i_free_valid && !busy[i_free_id];
    assign set_mask   = alloc_fire ? (SLOTS'(1) << o_alloc_id) : '0;
    assign clr_mask   = free_hit ? (SLOTS'(1) << i_free_id) : '0;
    assign busy_next  = (busy | set_mask) & ~clr_mask;

    always_comb begin
        next_valid = 1'b0;
        next_id    = '0;
        next_count = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (!busy_next[k]) begin
                next_valid = 1'b1;
                next_id    = ID_WIDTH'(k);
            end
        end
        for (int k = 0; k < SLOTS; k++) begin
            next_count = next_count + (ID_WIDTH+1)'(busy_next[k]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy          <= '0;
            o_alloc_valid <= 1'b1;
            o_alloc_id    <= '0;
            o_count       <= '0;
            o_free_error  <= 1'b0;
        end else begin
            busy          <= busy_next;
            o_alloc_valid <= next_valid;
            o_alloc_id    <= next_id;
            o_count       <= next_count;
            o_free_error  <= free_err;
        end
    end

    assign o_busy  = busy;
    assign o_full  = (o_count == (ID_WIDTH+1)'(SLOTS));
    assign o_empty = (o_count == '0);
endmodule

// File: doc/std_slot_allocator.md
# std_slot_allocator

Allocates and reclaims `SLOTS = 1 << ID_WIDTH` tag slots, handing out the lowest-numbered free slot as a binary ID over a valid/ready handshake. It sits directly upstream of `std_binary_decoder`. The granted `o_alloc_id` drives the decoder's `i_bin`, and `o_alloc_valid && i_alloc_ready` drives its `i_en`, producing the one-hot slot-select for downstream tables. It also accepts binary frees, flags illegal (double) frees, and exports occupancy status.

## Interface
Parameters:
- `ID_WIDTH`, default 3: width of the binary slot ID. Legal range is 1..8.
- `SLOTS`, localparam = `1 << ID_WIDTH`: number of tracked slots.

Ports:
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `o_alloc_valid`, output, 1: a free slot is offered on `o_alloc_id`.
- `o_alloc_id`, output, `ID_WIDTH`: lowest-numbered free slot, binary encoded.
- `i_alloc_ready`, input, 1: consumer takes the offered ID this cycle.
- `i_free_valid`, input, 1: release request.
- `i_free_id`, input, `ID_WIDTH`: slot being released, binary encoded.
- `o_free_error`, output, 1: one-cycle pulse; the previous cycle's free targeted a slot that was not busy.
- `o_busy`, output, `SLOTS`: occupancy vector; bit k = slot k allocated.
- `o_count`, output, `ID_WIDTH+1`: number of busy slots, 0..SLOTS.
- `o_full`, output, 1: `o_count == SLOTS`.
- `o_empty`, output, 1: `o_count == 0`.

## Operation
- State is the registered occupancy vector `busy[SLOTS]`. `o_busy` is that register.
- Allocate fires when `o_alloc_valid && i_alloc_ready`. It sets `busy[o_alloc_id]`.
- Free fires when `i_free_valid` is high:
  - `busy[i_free_id] == 1`: clear it.
  - `busy[i_free_id] == 0`: state is unchanged and `o_free_error` pulses next cycle. This includes the ID currently offered on `o_alloc_id`.
- Simultaneous allocate and legal free of different slots: both apply in the same edge.
- Free of the slot being allocated in the same cycle: that slot was free, so this is a double free. The allocate proceeds and the free is flagged as an error.
- `busy_next` = busy with allocate set and legal free cleared.
- Output register update each cycle, computed from `busy_next`:
  - `o_alloc_valid <= |~busy_next`.
  - `o_alloc_id <=` lowest index k with `busy_next[k] == 0`.
  - `o_alloc_id <= 0` when none is free.
  - `o_count <= popcount(busy_next)`.
- `o_full` and `o_empty` are decoded from the registered `o_count`. They may be combinational from that register.
- Handshake rules:
  - `o_alloc_valid` does not depend combinationally on `i_alloc_ready`.
  - While `o_alloc_valid && !i_alloc_ready`, `o_alloc_id` may change only if a free makes a lower index available. Consumers must sample the ID only on the handshake cycle.
- `i_alloc_ready` is ignored when `o_alloc_valid == 0`. A full allocator never grants.
- Reset, asynchronous and effective mid-operation:
  - `busy = 0`, `o_count = 0`, `o_empty = 1`, `o_full = 0`.
  - `o_alloc_valid = 1`, `o_alloc_id = 0`, `o_free_error = 0`.
  - Any handshake in flight is discarded.

## Timing
- Allocation throughput is one ID per cycle, back-to-back. Consecutive grants from empty are 0, 1, 2, ….
- Allocate at edge t:
  - `o_busy` bit visible after t.
  - Next offered ID, `o_count` and `o_full` all reflect it after the same edge.
- Free at edge t: the slot is re-offerable at cycle t+1 if it is the lowest free slot.
- `o_free_error` is high for exactly the cycle after the offending free.
- After reset release, a grant is possible on the first clock edge.
- Priority encoder and popcount are combinational on `busy_next`. The only sequential elements are `busy`, `o_alloc_valid`, `o_alloc_id`, `o_count` and `o_free_error`.

## Test plan
- Reset, then hold `i_alloc_ready=1` for 8 cycles (`ID_WIDTH=3`):
  - Grants 0..7 in order.
  - `o_busy` ends at `8'hFF`, `o_count=8`, `o_full=1`, `o_alloc_valid=0`.
- From full:
  - Free 5: next cycle `o_alloc_valid=1`, `o_alloc_id=5`, `o_count=7`.
  - Then free 2 with ready low: the offered ID changes to 2.
- Same cycle with busy=`8'h0F`: allocate ID 4 and free ID 1. After the edge busy=`8'h1D`, `o_alloc_id=1`, `o_count=4`.
- Double free: free ID 6 while busy=`8'h03` -> `o_free_error=1` for one cycle and busy unchanged. Also free the offered ID 2 -> error pulse, state unchanged.
- Assert `i_rst` mid-sequence with busy=`8'hA5` -> immediately busy=0, `o_alloc_id=0`, `o_alloc_valid=1`, `o_count=0`, `o_empty=1`.
- Random alloc/free for 10k cycles against a scoreboard:
  - `o_count == popcount(o_busy)`.
  - No ID is granted twice without an intervening free.
  - `std_binary_decoder` fed from `o_alloc_id` yields a one-hot output equal to the `o_busy` delta.
